// File: rtl/punc_control.sv
// Control FSM for the PUNC LC-3 subset: sequences fetch/decode/execute and
// drives datapath selects and strobes combinationally from state and ir.
module punc_control #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  output logic        ir_ld,
  output logic        pc_ld,
  output logic [1:0]  pc_sel,
  output logic [1:0]  mem_raddr_sel,
  output logic        mem_w_en,
  output logic [1:0]  mem_waddr_sel,
  output logic        rf_w_en,
  output logic        rf_waddr_sel,
  output logic [1:0]  rf_wdata_sel,
  output logic [1:0]  alu_op,
  output logic        cc_ld,
  output logic        temp_ld,
  output logic        halted,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] EXEC2  = 3'd3;
  localparam logic [2:0] HALT   = 3'd4;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RSV  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  logic [2:0] state_reg, state_next;
  logic [3:0] opcode;
  logic       illegal;
  logic       br_taken;
  logic       unused_ir;

  assign opcode    = ir[15:12];
  assign illegal   = (opcode == OP_RTI) || (opcode == OP_RSV);
  assign br_taken  = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
  assign unused_ir = ^ir[8:0];
  assign state_dbg = state_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= FETCH;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next    = FETCH;
    ir_ld         = 1'b0;
    pc_ld         = 1'b0;
    pc_sel        = 2'd0;
    mem_raddr_sel = 2'd0;
    mem_w_en      = 1'b0;
    mem_waddr_sel = 2'd0;
    rf_w_en       = 1'b0;
    rf_waddr_sel  = 1'b0;
    rf_wdata_sel  = 2'd0;
    alu_op        = 2'd0;
    cc_ld         = 1'b0;
    temp_ld       = 1'b0;
    halted        = 1'b0;
    case (state_reg)
      FETCH: begin
        ir_ld      = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        pc_ld = 1'b1;
        if (opcode == OP_TRAP || (ILLEGAL_HALT && illegal)) state_next = HALT;
        else                                                 state_next = EXEC;
      end
      EXEC: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: begin
            rf_w_en = 1'b1;
            cc_ld   = 1'b1;
            alu_op  = (opcode == OP_ADD) ? 2'd0 : (opcode == OP_AND) ? 2'd1 : 2'd2;
          end
          OP_LD, OP_LDR: begin
            rf_w_en       = 1'b1;
            rf_wdata_sel  = 2'd1;
            mem_raddr_sel = (opcode == OP_LD) ? 2'd1 : 2'd2;
            cc_ld         = 1'b1;
          end
          OP_LEA: begin
            rf_w_en      = 1'b1;
            rf_wdata_sel = 2'd3;
          end
          OP_ST, OP_STR: begin
            mem_w_en      = 1'b1;
            mem_waddr_sel = (opcode == OP_ST) ? 2'd0 : 2'd1;
          end
          OP_BR: begin
            if (br_taken) begin
              pc_ld  = 1'b1;
              pc_sel = 2'd1;
            end
          end
          OP_JMP: begin
            pc_ld  = 1'b1;
            pc_sel = 2'd2;
          end
          // R7 gets the incremented PC on the same edge the PC reloads.
          OP_JSR: begin
            rf_w_en      = 1'b1;
            rf_waddr_sel = 1'b1;
            rf_wdata_sel = 2'd2;
            pc_ld        = 1'b1;
            pc_sel       = ir[11] ? 2'd3 : 2'd2;
          end
          OP_LDI, OP_STI: begin
            temp_ld       = 1'b1;
            mem_raddr_sel = 2'd1;
            state_next    = EXEC2;
          end
          default: ;
        endcase
      end
      EXEC2: begin
        if (opcode == OP_LDI) begin
          rf_w_en       = 1'b1;
          rf_wdata_sel  = 2'd1;
          mem_raddr_sel = 2'd3;
          cc_ld         = 1'b1;
        end else if (opcode == OP_STI) begin
          mem_w_en      = 1'b1;
          mem_waddr_sel = 2'd2;
        end
      end
      HALT: begin
        halted     = 1'b1;
        state_next = HALT;
      end
      default: state_next = FETCH;
    endcase
  end

endmodule

// File: tb/tb_punc_control.sv
// Scoreboard bench for punc_control: expected control vectors are queued per
// cycle as instructions are driven and compared at each falling clock edge.
module tb_punc_control;

  typedef struct packed {
    logic       ir_ld;
    logic       pc_ld;
    logic [1:0] pc_sel;
    logic [1:0] mem_raddr_sel;
    logic       mem_w_en;
    logic [1:0] mem_waddr_sel;
    logic       rf_w_en;
    logic       rf_waddr_sel;
    logic [1:0] rf_wdata_sel;
    logic [1:0] alu_op;
    logic       cc_ld;
    logic       temp_ld;
    logic       halted;
    logic [2:0] state_dbg;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir = 16'h0000;
  logic        n = 1'b0, z = 1'b0, p = 1'b0;

  logic       ir_ld_a, pc_ld_a, mem_w_en_a, rf_w_en_a, rf_waddr_sel_a, cc_ld_a, temp_ld_a, halted_a;
  logic [1:0] pc_sel_a, mem_raddr_sel_a, mem_waddr_sel_a, rf_wdata_sel_a, alu_op_a;
  logic [2:0] state_dbg_a;
  logic       ir_ld_b, pc_ld_b, mem_w_en_b, rf_w_en_b, rf_waddr_sel_b, cc_ld_b, temp_ld_b, halted_b;
  logic [1:0] pc_sel_b, mem_raddr_sel_b, mem_waddr_sel_b, rf_wdata_sel_b, alu_op_b;
  logic [2:0] state_dbg_b;

  ctl_t obs_a, obs_b;
  assign obs_a = {ir_ld_a, pc_ld_a, pc_sel_a, mem_raddr_sel_a, mem_w_en_a, mem_waddr_sel_a,
                  rf_w_en_a, rf_waddr_sel_a, rf_wdata_sel_a, alu_op_a, cc_ld_a, temp_ld_a,
                  halted_a, state_dbg_a};
  assign obs_b = {ir_ld_b, pc_ld_b, pc_sel_b, mem_raddr_sel_b, mem_w_en_b, mem_waddr_sel_b,
                  rf_w_en_b, rf_waddr_sel_b, rf_wdata_sel_b, alu_op_b, cc_ld_b, temp_ld_b,
                  halted_b, state_dbg_b};

  punc_control dut (
    .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
    .ir_ld(ir_ld_a), .pc_ld(pc_ld_a), .pc_sel(pc_sel_a), .mem_raddr_sel(mem_raddr_sel_a),
    .mem_w_en(mem_w_en_a), .mem_waddr_sel(mem_waddr_sel_a), .rf_w_en(rf_w_en_a),
    .rf_waddr_sel(rf_waddr_sel_a), .rf_wdata_sel(rf_wdata_sel_a), .alu_op(alu_op_a),
    .cc_ld(cc_ld_a), .temp_ld(temp_ld_a), .halted(halted_a), .state_dbg(state_dbg_a)
  );

  punc_control #(.ILLEGAL_HALT(1'b0)) dut_nop (
    .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
    .ir_ld(ir_ld_b), .pc_ld(pc_ld_b), .pc_sel(pc_sel_b), .mem_raddr_sel(mem_raddr_sel_b),
    .mem_w_en(mem_w_en_b), .mem_waddr_sel(mem_waddr_sel_b), .rf_w_en(rf_w_en_b),
    .rf_waddr_sel(rf_waddr_sel_b), .rf_wdata_sel(rf_wdata_sel_b), .alu_op(alu_op_b),
    .cc_ld(cc_ld_b), .temp_ld(temp_ld_b), .halted(halted_b), .state_dbg(state_dbg_b)
  );

  always #5 clk = ~clk;

  int cmp_count = 0;
  int err_count = 0;
  ctl_t  exp_a_q[$];
  ctl_t  exp_b_q[$];
  string tag_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    cmp_count++;
    if (got !== want) begin
      err_count++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  function automatic ctl_t st(input logic [2:0] s);
    ctl_t c;
    c = '0;
    c.state_dbg = s;
    c.ir_ld     = (s == 3'd0);
    c.halted    = (s == 3'd4);
    return c;
  endfunction

  function automatic ctl_t dec();
    ctl_t c;
    c = st(3'd1);
    c.pc_ld = 1'b1;
    return c;
  endfunction

  task automatic push(input string tag, input ctl_t ea, input ctl_t eb);
    tag_q.push_back(tag);
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
  endtask

  task automatic compare_now();
    string tag;
    ctl_t  ea, eb;
    if (exp_a_q.size() == 0) begin
      err_count++;
      $display("FAIL scoreboard: queue empty at compare");
      return;
    end
    tag = tag_q.pop_front();
    ea  = exp_a_q.pop_front();
    eb  = exp_b_q.pop_front();
    check({tag, "/halt1"}, 32'(obs_a), 32'(ea));
    check({tag, "/halt0"}, 32'(obs_b), 32'(eb));
  endtask

  task automatic drain();
    while (exp_a_q.size() > 0) begin
      @(negedge clk);
      compare_now();
    end
  endtask

  // Entered with both FSMs in FETCH just after a rising edge.
  task automatic run(input string tag, input logic [15:0] instr, input logic [2:0] nzp,
                     input ctl_t ex, input bit two, input ctl_t ex2);
    ir = instr;
    {n, z, p} = nzp;
    push({tag, "/fetch"}, st(3'd0), st(3'd0));
    push({tag, "/decode"}, dec(), dec());
    push({tag, "/exec"}, ex, ex);
    if (two) push({tag, "/exec2"}, ex2, ex2);
    drain();
    $display("instr %-10s ir=%h nzp=%b checked, %0d mismatches so far", tag, instr, nzp, err_count);
    @(posedge clk);
    #1;
  endtask

  task automatic run_halt(input string tag, input logic [15:0] instr, input bit nop_halts);
    ctl_t eb;
    ir = instr;
    {n, z, p} = 3'b000;
    push({tag, "/fetch"}, st(3'd0), st(3'd0));
    push({tag, "/decode"}, dec(), dec());
    for (int i = 0; i < 12; i++) begin
      if (nop_halts)       eb = st(3'd4);
      else if (i % 3 == 0) eb = st(3'd2);
      else if (i % 3 == 1) eb = st(3'd0);
      else                 eb = dec();
      push($sformatf("%s/hold%0d", tag, i), st(3'd4), eb);
    end
    drain();
    rst = 1'b1;
    #1;
    push({tag, "/rst"}, st(3'd0), st(3'd0));
    compare_now();
    $display("instr %-10s ir=%h halt sequence checked, %0d mismatches so far", tag, instr, err_count);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    ctl_t e, x;
    repeat (2) @(posedge clk);
    #1;
    push("reset", st(3'd0), st(3'd0));
    compare_now();
    rst = 1'b0;

    e = st(3'd2); e.rf_w_en = 1'b1; e.cc_ld = 1'b1;
    run("add", 16'h1261, 3'b000, e, 1'b0, e);
    e.alu_op = 2'd1;
    run("and", 16'h5042, 3'b000, e, 1'b0, e);
    e.alu_op = 2'd2;
    run("not", 16'h927F, 3'b000, e, 1'b0, e);

    e = st(3'd2); e.rf_w_en = 1'b1; e.rf_wdata_sel = 2'd1; e.mem_raddr_sel = 2'd1; e.cc_ld = 1'b1;
    run("ld", 16'h2205, 3'b000, e, 1'b0, e);
    e.mem_raddr_sel = 2'd2;
    run("ldr", 16'h6283, 3'b000, e, 1'b0, e);
    e = st(3'd2); e.rf_w_en = 1'b1; e.rf_wdata_sel = 2'd3;
    run("lea", 16'hE7FF, 3'b111, e, 1'b0, e);

    e = st(3'd2); e.mem_w_en = 1'b1;
    run("st", 16'h3A10, 3'b000, e, 1'b0, e);
    e.mem_waddr_sel = 2'd1;
    run("str", 16'h7A41, 3'b000, e, 1'b0, e);

    e = st(3'd2);
    run("br_z", 16'h0A05, 3'b010, e, 1'b0, e);
    run("br_none", 16'h0000, 3'b111, e, 1'b0, e);
    e.pc_ld = 1'b1; e.pc_sel = 2'd1;
    run("br_p", 16'h0A05, 3'b001, e, 1'b0, e);
    run("br_n", 16'h0805, 3'b100, e, 1'b0, e);

    e = st(3'd2); e.pc_ld = 1'b1; e.pc_sel = 2'd2;
    run("jmp", 16'hC1C0, 3'b000, e, 1'b0, e);
    e.rf_w_en = 1'b1; e.rf_waddr_sel = 1'b1; e.rf_wdata_sel = 2'd2;
    run("jsrr", 16'h41C0, 3'b000, e, 1'b0, e);
    e.pc_sel = 2'd3;
    run("jsr", 16'h4FFF, 3'b000, e, 1'b0, e);

    e = st(3'd2); e.temp_ld = 1'b1; e.mem_raddr_sel = 2'd1;
    x = st(3'd3); x.rf_w_en = 1'b1; x.rf_wdata_sel = 2'd1; x.mem_raddr_sel = 2'd3; x.cc_ld = 1'b1;
    run("ldi", 16'hA402, 3'b000, e, 1'b1, x);
    x = st(3'd3); x.mem_w_en = 1'b1; x.mem_waddr_sel = 2'd2;
    run("sti", 16'hB602, 3'b000, e, 1'b1, x);

    // Reset asserted between clock edges while STI is writing in EXEC2.
    ir = 16'hB602;
    push("sti_rst/fetch", st(3'd0), st(3'd0));
    push("sti_rst/decode", dec(), dec());
    push("sti_rst/exec", e, e);
    push("sti_rst/exec2", x, x);
    drain();
    #2;
    rst = 1'b1;
    #1;
    push("sti_rst/async", st(3'd0), st(3'd0));
    compare_now();
    @(negedge clk);
    push("sti_rst/held", st(3'd0), st(3'd0));
    compare_now();
    @(posedge clk);
    #1;
    rst = 1'b0;
    run("sti_resume", 16'hB602, 3'b000, e, 1'b1, x);

    run_halt("trap", 16'hF025, 1'b1);
    run_halt("rsv", 16'hD000, 1'b0);
    run_halt("rti", 16'h8000, 1'b0);

    e = st(3'd2); e.rf_w_en = 1'b1; e.cc_ld = 1'b1;
    run("add_post", 16'h1261, 3'b000, e, 1'b0, e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
